store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
Parametrised successor to the WB-stage store write-control logic. Decodes RISC-V stores (SB/SH/SW, plus SD when XLEN=64) into lane-aligned write data and byte masks. Queues each store in a DEPTH-entry FIFO and drains it to the memory side over a valid/ready handshake. Provides load-hazard lookup and misalignment reporting; sits between the execute/WB stage and the DMEM/IMEM/MMIO write ports.

Parameters:
XLEN, 32, data/address datapath width; legal values 32 or 64
DEPTH, 4, store buffer entries; power of two, at least 2
LANES, XLEN/8, byte lanes; derived, not overridable

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  synchronous, active-low reset
req_valid  in  1  store candidate from pipeline
req_ready  out  1  buffer can accept this cycle
req_opcode  in  7  instruction[6:0]
req_funct3  in  3  instruction[14:12]
req_addr  in  XLEN  effective address (ALU result)
req_data  in  XLEN  raw rs2 data
req_pc  in  32  PC of the store; bit 30 set = BIOS mode
mem_valid  out  1  head entry presented
mem_ready  in  1  memory side accepts head
mem_tgt  out  3  {mmio, imem, dmem} write target mask
mem_addr  out  XLEN  word/dword-aligned address
mem_wea  out  LANES  byte write enables
mem_wdata  out  XLEN  lane-shifted data, unused lanes zero
ld_addr  in  XLEN  address of load in the pipeline
ld_hit  out  1  a buffered store overlaps the load's aligned word
empty  out  1  no valid entries (fence/drain indicator)
misalign_err  out  1  one-cycle pulse on a misaligned store
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst_n=0 at a clock edge): all entries invalid; head=tail=0; count=0; empty=1; mem_valid=0; misalign_err=0. The FIFO contents are don't-care. Reset mid-drain discards queued stores and emits no further mem_valid.
- req_ready = (count<DEPTH) || (mem_valid && mem_ready). Simultaneous enqueue and dequeue is allowed when full.
- Accept means req_valid && req_ready. Non-store opcodes are accepted and discarded: no enqueue, no error.
- Region decode uses addr[31:28]. Values 0001, 0011 and 0010 are memory; 1000 is MMIO.
  - dmem bit = addr[28].
  - imem bit = addr[29] && req_pc[30].
  - mmio bit = (addr[31:28]==1000).
  - If the resulting tgt is 000, the store is accepted and dropped.
- Alignment: SH requires addr[0]=0; SW requires addr[1:0]=0; SD requires addr[2:0]=0. A misaligned store is accepted, not enqueued, and misalign_err pulses high in the following cycle.
- Illegal funct3 (including SD when XLEN=32) is dropped silently.
- Lane shift uses a byte offset of addr[1:0] (XLEN=32) or addr[2:0] (XLEN=64).
  - SB: one mask bit at the offset; data byte placed in that lane.
  - SH: two bits. SW: four bits. SD: all eight.
  - All other lanes are zero.
- mem_addr = req_addr with the offset bits cleared.
- Drain: mem_valid = !empty, driven from the head entry's registers with no combinational path from req_*. Entry pops when mem_valid && mem_ready. mem_* are held stable while mem_valid && !mem_ready.
- Latency: a store accepted at cycle N is presented on mem_* at cycle N+1 at the earliest.
- ld_hit is combinational. It is 1 if any valid entry's mem_addr equals ld_addr with the offset bits cleared, regardless of byte mask. An entry popping in the current cycle still counts.
- Pointer wrap: head and tail are modulo DEPTH. count distinguishes full from empty.
- count and empty update on the same edge as push/pop. Simultaneous push and pop leaves count unchanged.

Decomposition:
- Shared package holds:
  - opcode/funct3 constants (OPC_STORE, FNC_SB/SH/SW/SD), taken from the existing Opcode definitions
  - region nibble constants
  - the target-bit index constants
- One sub-module, store_lane_align: combinational funct3/offset to {wea, wdata, misaligned, legal}, parametrised by XLEN.
- The FIFO and hazard compare stay in the top module.

Test Plan:
- SB at 0x1000_0003, data 0xAB, PC 0x0000_1000: next cycle mem_tgt=001, mem_addr=0x1000_0000, wea=1000, wdata=0xAB00_0000.
- SW to 0x2000_0010, first with PC 0x4000_0000, then with PC 0x0000_0000: first gives tgt=010, wea=1111; second is dropped, empty stays 1.
- SH at 0x1000_0001: no mem_valid; misalign_err=1 for exactly one cycle.
- Hold mem_ready=0 and issue 5 SWs with DEPTH=4: req_ready=0 after 4. Then assert mem_ready: drain order matches, count goes 4→0, and a 5th accepted on the full+pop cycle appears last.
- Buffered SW at 0x1000_0020; ld_addr=0x1000_0022 → ld_hit=1; ld_addr=0x1000_0024 → ld_hit=0.
- XLEN=64: SD at 0x1000_0008 → wea=0xFF; SD at 0x1000_0004 → misalign_err. Also assert rst_n=0 with 3 entries queued → next cycle empty=1, mem_valid=0.

Source files
------------

// File: rtl/store_write_buffer_pkg.sv
// Shared constants for the store write buffer: store opcode/funct3 encodings,
// address region nibbles and write-target bit positions.
package store_write_buffer_pkg;

    // RV32I/RV64I store major opcode and width encodings
    localparam logic [6:0] OPC_STORE = 7'b010_0011;
    localparam logic [2:0] FNC_SB    = 3'b000;
    localparam logic [2:0] FNC_SH    = 3'b001;
    localparam logic [2:0] FNC_SW    = 3'b010;
    localparam logic [2:0] FNC_SD    = 3'b011;

    // addr[31:28] region nibbles
    localparam logic [3:0] RGN_DMEM_LO = 4'b0001;
    localparam logic [3:0] RGN_IMEM    = 4'b0010;
    localparam logic [3:0] RGN_DMEM_HI = 4'b0011;
    localparam logic [3:0] RGN_MMIO    = 4'b1000;

    // Bit positions inside the {mmio, imem, dmem} target mask
    localparam int unsigned TGT_DMEM = 0;
    localparam int unsigned TGT_IMEM = 1;
    localparam int unsigned TGT_MMIO = 2;
    localparam int unsigned TGT_W    = 3;

    typedef logic [TGT_W-1:0] tgt_t;

endpackage

// File: rtl/store_write_buffer_if.sv
// Pipeline-side request, memory-side drain and load-hazard signals of the
// store write buffer. master = surrounding pipeline/memory, slave = buffer.
interface store_write_buffer_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LANES = XLEN / 8;
    localparam int unsigned CNTW  = $clog2(DEPTH) + 1;

    logic              req_valid;
    logic              req_ready;
    logic [6:0]        req_opcode;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_data;
    logic [31:0]       req_pc;

    logic              mem_valid;
    logic              mem_ready;
    logic [2:0]        mem_tgt;
    logic [XLEN-1:0]   mem_addr;
    logic [LANES-1:0]  mem_wea;
    logic [XLEN-1:0]   mem_wdata;

    logic [XLEN-1:0]   ld_addr;
    logic              ld_hit;
    logic              empty;
    logic              misalign_err;
    logic [CNTW-1:0]   count;

    modport master (
        output req_valid, req_opcode, req_funct3, req_addr, req_data, req_pc,
        input  req_ready,
        input  mem_valid, mem_tgt, mem_addr, mem_wea, mem_wdata,
        output mem_ready,
        output ld_addr,
        input  ld_hit, empty, misalign_err, count
    );

    modport slave (
        input  req_valid, req_opcode, req_funct3, req_addr, req_data, req_pc,
        output req_ready,
        output mem_valid, mem_tgt, mem_addr, mem_wea, mem_wdata,
        input  mem_ready,
        input  ld_addr,
        output ld_hit, empty, misalign_err, count
    );

endinterface

// File: rtl/store_write_buffer_lane_align.sv
// Combinational store width decode: funct3 + byte offset to lane enables,
// lane-shifted data, misalignment and legality flags.
module store_lane_align
    import store_write_buffer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]                   funct3,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  logic [XLEN-1:0]              data,
    output logic [XLEN/8-1:0]            wea_c,
    output logic [XLEN-1:0]              wdata_c,
    output logic                         misaligned_c,
    output logic                         legal_c
);
    localparam int unsigned LANES = XLEN / 8;
    localparam int unsigned OFFW  = $clog2(LANES);

    logic [LANES-1:0] base_mask;
    logic [XLEN-1:0]  data_mask;

    // Width decode, then shift the unshifted lane mask and masked data into place
    always_comb begin
        legal_c      = 1'b0;
        misaligned_c = 1'b0;
        base_mask    = '0;
        data_mask    = '0;
        case (funct3)
            FNC_SB: begin
                legal_c   = 1'b1;
                base_mask = LANES'(1'b1);
            end
            FNC_SH: begin
                legal_c      = 1'b1;
                base_mask    = LANES'(2'b11);
                misaligned_c = offset[0];
            end
            FNC_SW: begin
                legal_c      = 1'b1;
                base_mask    = LANES'(4'hF);
                misaligned_c = |offset[1:0];
            end
            FNC_SD: begin
                if (XLEN == 64) begin
                    legal_c      = 1'b1;
                    base_mask    = '1;
                    misaligned_c = |offset;
                end
            end
            default: begin
            end
        endcase
        for (int i = 0; i < int'(LANES); i++) begin
            data_mask[8*i +: 8] = {8{base_mask[i]}};
        end
        wea_c   = base_mask << offset;
        wdata_c = (data & data_mask) << {offset, 3'b000};
    end

    logic unused_offw;
    assign unused_offw = OFFW[0];

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: decodes RISC-V stores into lane-aligned writes, queues
// them in a DEPTH-entry FIFO and drains to memory over valid/ready. Also
// flags misaligned stores and answers load-hazard lookups.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    store_write_buffer_if.slave  bus
);
    localparam int unsigned LANES = XLEN / 8;
    localparam int unsigned OFFW  = $clog2(LANES);
    localparam int unsigned PTRW  = $clog2(DEPTH);
    localparam int unsigned CNTW  = PTRW + 1;

    tgt_t             tgt_q   [DEPTH];
    tgt_t             tgt_d   [DEPTH];
    logic [XLEN-1:0]  addr_q  [DEPTH];
    logic [XLEN-1:0]  addr_d  [DEPTH];
    logic [LANES-1:0] wea_q   [DEPTH];
    logic [LANES-1:0] wea_d   [DEPTH];
    logic [XLEN-1:0]  wdata_q [DEPTH];
    logic [XLEN-1:0]  wdata_d [DEPTH];

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTRW-1:0]  head_q, head_d;
    logic [PTRW-1:0]  tail_q, tail_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             empty_q, empty_d;
    logic             misalign_q, misalign_d;

    logic [LANES-1:0] lane_wea_c;
    logic [XLEN-1:0]  lane_wdata_c;
    logic             misaligned_c;
    logic             legal_c;

    tgt_t             req_tgt;
    logic [XLEN-1:0]  req_aligned;
    logic [XLEN-1:0]  ld_aligned;
    logic             accept;
    logic             is_store;
    logic             push;
    logic             pop;

    store_lane_align #(.XLEN(XLEN)) u_lane_align (
        .funct3       (bus.req_funct3),
        .offset       (bus.req_addr[OFFW-1:0]),
        .data         (bus.req_data),
        .wea_c        (lane_wea_c),
        .wdata_c      (lane_wdata_c),
        .misaligned_c (misaligned_c),
        .legal_c      (legal_c)
    );

    // Region decode into the {mmio, imem, dmem} target mask
    always_comb begin
        req_tgt           = '0;
        req_tgt[TGT_DMEM] = bus.req_addr[28];
        req_tgt[TGT_IMEM] = bus.req_addr[29] && bus.req_pc[30];
        req_tgt[TGT_MMIO] = (bus.req_addr[31:28] == RGN_MMIO);
    end

    assign req_aligned   = {bus.req_addr[XLEN-1:OFFW], OFFW'(0)};
    assign ld_aligned    = {bus.ld_addr[XLEN-1:OFFW], OFFW'(0)};
    assign pop           = !empty_q && bus.mem_ready;
    assign bus.req_ready = (count_q < CNTW'(DEPTH)) || pop;
    assign accept        = bus.req_valid && bus.req_ready;
    assign is_store      = (bus.req_opcode == OPC_STORE);
    assign push          = accept && is_store && legal_c && !misaligned_c && (req_tgt != '0);

    // Pointer, occupancy and error-pulse next state
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        valid_d    = valid_q;
        misalign_d = accept && is_store && legal_c && misaligned_c;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTRW'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTRW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
    end

    // Payload write into the tail slot
    always_comb begin
        tgt_d   = tgt_q;
        addr_d  = addr_q;
        wea_d   = wea_q;
        wdata_d = wdata_q;
        if (push) begin
            tgt_d[tail_q]   = req_tgt;
            addr_d[tail_q]  = req_aligned;
            wea_d[tail_q]   = lane_wea_c;
            wdata_d[tail_q] = lane_wdata_c;
        end
    end

    // Control state with synchronous reset; queued stores are discarded
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            misalign_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            misalign_q <= misalign_d;
        end
    end

    // Payload storage needs no reset; only valid entries are ever presented
    always_ff @(posedge clk) begin
        tgt_q   <= tgt_d;
        addr_q  <= addr_d;
        wea_q   <= wea_d;
        wdata_q <= wdata_d;
    end

    // Load hazard: any valid entry targeting the load's aligned word
    always_comb begin
        bus.ld_hit = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && (addr_q[i] == ld_aligned)) begin
                bus.ld_hit = 1'b1;
            end
        end
    end

    assign bus.mem_valid    = !empty_q;
    assign bus.mem_tgt      = tgt_q[head_q];
    assign bus.mem_addr     = addr_q[head_q];
    assign bus.mem_wea      = wea_q[head_q];
    assign bus.mem_wdata    = wdata_q[head_q];
    assign bus.empty        = empty_q;
    assign bus.count        = count_q;
    assign bus.misalign_err = misalign_q;

    logic unused_pc;
    assign unused_pc = ^{bus.req_pc[31], bus.req_pc[29:0], bus.ld_addr[OFFW-1:0]};

endmodule

// File: tb/tb_store_write_buffer.sv
// Randomized + directed bench for store_write_buffer; drives an XLEN=32 and an
// XLEN=64 instance with shared stimulus and compares both to queue models.
module tb_store_write_buffer;
    localparam int unsigned DEPTH = 4;
    localparam logic [6:0]  OPC_ST = 7'h23;

    typedef struct packed {
        logic [2:0]  tgt;
        logic [63:0] addr;
        logic [7:0]  wea;
        logic [63:0] wdata;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        s_valid;
    logic [6:0]  s_opc;
    logic [2:0]  s_f3;
    logic [63:0] s_addr;
    logic [63:0] s_data;
    logic [31:0] s_pc;
    logic        s_mem_ready;
    logic [63:0] s_ld_addr;

    int n_vec = 0;
    int n_err = 0;

    ent_t q32[$];
    ent_t q64[$];
    logic exp_mis32 = 1'b0;
    logic exp_mis64 = 1'b0;

    store_write_buffer_if #(.XLEN(32), .DEPTH(DEPTH)) bus32 ();
    store_write_buffer_if #(.XLEN(64), .DEPTH(DEPTH)) bus64 ();

    assign bus32.req_valid  = s_valid;
    assign bus32.req_opcode = s_opc;
    assign bus32.req_funct3 = s_f3;
    assign bus32.req_addr   = s_addr[31:0];
    assign bus32.req_data   = s_data[31:0];
    assign bus32.req_pc     = s_pc;
    assign bus32.mem_ready  = s_mem_ready;
    assign bus32.ld_addr    = s_ld_addr[31:0];

    assign bus64.req_valid  = s_valid;
    assign bus64.req_opcode = s_opc;
    assign bus64.req_funct3 = s_f3;
    assign bus64.req_addr   = s_addr;
    assign bus64.req_data   = s_data;
    assign bus64.req_pc     = s_pc;
    assign bus64.mem_ready  = s_mem_ready;
    assign bus64.ld_addr    = s_ld_addr;

    store_write_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32.slave));
    store_write_buffer #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .rst_n(rst_n), .bus(bus64.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] xmask(input int xl);
        return (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Reference decode straight from the store rules
    function automatic void decode(input int xl, input logic [6:0] o, input logic [2:0] f,
                                   input logic [63:0] a_in, input logic [63:0] d_in,
                                   input logic [31:0] pc, output logic enq,
                                   output logic mis, output ent_t e);
        logic [63:0] a, d, dm;
        int sz, off, lanes;
        lanes = xl / 8;
        a = a_in & xmask(xl);
        d = d_in & xmask(xl);
        case (f)
            3'd0:    sz = 1;
            3'd1:    sz = 2;
            3'd2:    sz = 4;
            3'd3:    sz = (xl == 64) ? 8 : 0;
            default: sz = 0;
        endcase
        off    = int'(a % 64'(lanes));
        mis    = (o == OPC_ST) && (sz != 0) && ((off % ((sz == 0) ? 1 : sz)) != 0);
        e.tgt  = {a[31:28] == 4'h8, a[29] & pc[30], a[28]};
        e.addr = a - 64'(off);
        e.wea  = 8'(((1 << sz) - 1) << off);
        dm     = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
        e.wdata = (d & dm) << (8 * off);
        enq    = (o == OPC_ST) && (sz != 0) && !mis && (e.tgt != 3'b000);
    endfunction

    task automatic check_side(input string p, input int xl, input ent_t q[$], input logic exp_mis,
                              input logic o_ready, input logic o_mvalid, input logic [2:0] o_tgt,
                              input logic [63:0] o_addr, input logic [7:0] o_wea,
                              input logic [63:0] o_wdata, input logic o_hit, input logic o_empty,
                              input logic o_mis, input logic [7:0] o_count);
        logic [63:0] la;
        logic e_hit;
        int n;
        n  = q.size();
        la = s_ld_addr & xmask(xl);
        la = la - (la % 64'(xl / 8));
        e_hit = 1'b0;
        foreach (q[i]) if (q[i].addr == la) e_hit = 1'b1;
        check({p, ".req_ready"}, 64'(o_ready),
              64'((n < int'(DEPTH)) || (n > 0 && s_mem_ready)));
        check({p, ".mem_valid"}, 64'(o_mvalid), 64'(n > 0));
        check({p, ".empty"},     64'(o_empty),  64'(n == 0));
        check({p, ".count"},     64'(o_count),  64'(n));
        check({p, ".misalign"},  64'(o_mis),    64'(exp_mis));
        check({p, ".ld_hit"},    64'(o_hit),    64'(e_hit));
        if (n > 0) begin
            check({p, ".mem_tgt"},   64'(o_tgt),  64'(q[0].tgt));
            check({p, ".mem_addr"},  o_addr,      q[0].addr);
            check({p, ".mem_wea"},   64'(o_wea),  64'(q[0].wea));
            check({p, ".mem_wdata"}, o_wdata,     q[0].wdata);
        end
    endtask

    // One clock: check outputs against the model, then advance the model
    task automatic step();
        logic enq32, mis32, enq64, mis64, acc32, acc64, pop32, pop64;
        ent_t e32, e64;
        int n32, n64;
        #1;
        check_side("x32", 32, q32, exp_mis32, bus32.req_ready, bus32.mem_valid, bus32.mem_tgt,
                   64'(bus32.mem_addr), 8'(bus32.mem_wea), 64'(bus32.mem_wdata),
                   bus32.ld_hit, bus32.empty, bus32.misalign_err, 8'(bus32.count));
        check_side("x64", 64, q64, exp_mis64, bus64.req_ready, bus64.mem_valid, bus64.mem_tgt,
                   bus64.mem_addr, bus64.mem_wea, bus64.mem_wdata,
                   bus64.ld_hit, bus64.empty, bus64.misalign_err, 8'(bus64.count));
        n32 = q32.size();
        n64 = q64.size();
        pop32 = (n32 > 0) && s_mem_ready;
        pop64 = (n64 > 0) && s_mem_ready;
        acc32 = s_valid && ((n32 < int'(DEPTH)) || pop32);
        acc64 = s_valid && ((n64 < int'(DEPTH)) || pop64);
        decode(32, s_opc, s_f3, s_addr, s_data, s_pc, enq32, mis32, e32);
        decode(64, s_opc, s_f3, s_addr, s_data, s_pc, enq64, mis64, e64);
        @(posedge clk);
        if (!rst_n) begin
            q32.delete();
            q64.delete();
            exp_mis32 = 1'b0;
            exp_mis64 = 1'b0;
        end else begin
            if (pop32) void'(q32.pop_front());
            if (pop64) void'(q64.pop_front());
            if (acc32 && enq32) q32.push_back(e32);
            if (acc64 && enq64) q64.push_back(e64);
            exp_mis32 = acc32 && mis32;
            exp_mis64 = acc64 && mis64;
        end
        @(negedge clk);
    endtask

    task automatic set_store(input logic [2:0] f, input logic [63:0] a,
                             input logic [63:0] d, input logic [31:0] pc);
        s_valid = 1'b1;
        s_opc   = OPC_ST;
        s_f3    = f;
        s_addr  = a;
        s_data  = d;
        s_pc    = pc;
    endtask

    task automatic set_idle();
        s_valid = 1'b0;
        s_opc   = 7'h13;
    endtask

    initial begin
        logic [3:0] nib;
        rst_n = 1'b0;
        s_mem_ready = 1'b1;
        s_ld_addr = '0;
        s_addr = '0;
        s_data = '0;
        s_pc = '0;
        s_f3 = '0;
        set_idle();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset state
        #1;
        check("rst.empty", 64'(bus32.empty), 64'd1);
        check("rst.count", 64'(bus32.count), 64'd0);
        check("rst.mem_valid", 64'(bus64.mem_valid), 64'd0);
        step();

        // SB at byte 3 of a DMEM word
        set_store(3'd0, 64'h1000_0003, 64'hAB, 32'h0000_1000);
        step();
        set_idle();
        #1;
        check("sb.mem_tgt",   64'(bus32.mem_tgt),   64'h1);
        check("sb.mem_addr",  64'(bus32.mem_addr),  64'h1000_0000);
        check("sb.mem_wea",   64'(bus32.mem_wea),   64'h8);
        check("sb.mem_wdata", 64'(bus32.mem_wdata), 64'hAB00_0000);
        step();

        // SW to IMEM region: BIOS PC targets imem, normal PC drops
        set_store(3'd2, 64'h2000_0010, 64'h1234_5678, 32'h4000_0000);
        step();
        set_idle();
        #1;
        check("sw_bios.mem_tgt", 64'(bus32.mem_tgt), 64'h2);
        check("sw_bios.mem_wea", 64'(bus32.mem_wea), 64'hF);
        step();
        set_store(3'd2, 64'h2000_0010, 64'h1234_5678, 32'h0000_0000);
        step();
        set_idle();
        #1;
        check("sw_user.empty", 64'(bus32.empty), 64'd1);
        step();

        // misaligned SH
        set_store(3'd1, 64'h1000_0001, 64'hBEEF, 32'h0);
        step();
        set_idle();
        #1;
        check("sh_mis.err",       64'(bus32.misalign_err), 64'd1);
        check("sh_mis.mem_valid", 64'(bus32.mem_valid),    64'd0);
        step();
        check("sh_mis.err_clear", 64'(bus32.misalign_err), 64'd0);

        // fill with memory stalled, then drain with 5th accepted on full+pop
        s_mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_store(3'd2, 64'h1000_0100 + 64'(4 * i), 64'(32'hC0DE_0000 + i), 32'h0);
            step();
        end
        set_store(3'd2, 64'h1000_0200, 64'hC0DE_0004, 32'h0);
        #1;
        check("full.req_ready", 64'(bus32.req_ready), 64'd0);
        check("full.count",     64'(bus32.count),     64'd4);
        step();
        s_mem_ready = 1'b1;
        step();
        set_idle();
        for (int i = 0; i < 6; i++) step();

        // load hazard on a buffered word
        s_mem_ready = 1'b0;
        set_store(3'd2, 64'h1000_0020, 64'h5555_AAAA, 32'h0);
        step();
        set_idle();
        s_ld_addr = 64'h1000_0022;
        #1;
        check("ldhit.same_word", 64'(bus32.ld_hit), 64'd1);
        step();
        s_ld_addr = 64'h1000_0024;
        #1;
        check("ldhit.next_word", 64'(bus32.ld_hit), 64'd0);
        step();
        s_mem_ready = 1'b1;
        step();
        step();

        // SD: full dword on XLEN=64, illegal on XLEN=32
        set_store(3'd3, 64'h1000_0008, 64'h0123_4567_89AB_CDEF, 32'h0);
        step();
        set_store(3'd3, 64'h1000_0004, 64'h0123_4567_89AB_CDEF, 32'h0);
        #1;
        check("sd.wea64",   64'(bus64.mem_wea), 64'hFF);
        check("sd.empty32", 64'(bus32.empty),   64'd1);
        step();
        set_idle();
        #1;
        check("sd_mis.err64", 64'(bus64.misalign_err), 64'd1);
        check("sd_mis.err32", 64'(bus32.misalign_err), 64'd0);
        step();

        // reset with entries queued
        s_mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_store(3'd2, 64'h1000_0300 + 64'(4 * i), 64'(i), 32'h0);
            step();
        end
        set_idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("rst_mid.empty",     64'(bus32.empty),     64'd1);
        check("rst_mid.mem_valid", 64'(bus64.mem_valid), 64'd0);
        s_mem_ready = 1'b1;
        step();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            case ($urandom_range(0, 4))
                0: nib = 4'h1;
                1: nib = 4'h2;
                2: nib = 4'h3;
                3: nib = 4'h8;
                default: nib = 4'($urandom);
            endcase
            s_valid = ($urandom_range(0, 3) != 0);
            s_opc   = ($urandom_range(0, 7) == 0) ? 7'h13 : OPC_ST;
            s_f3    = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 3));
            s_addr  = {32'($urandom_range(0, 1)), nib, 20'h0, 8'($urandom_range(0, 63))};
            s_data  = {32'($urandom), 32'($urandom)};
            s_pc    = 32'($urandom);
            s_mem_ready = ($urandom_range(0, 2) != 0);
            s_ld_addr = {32'($urandom_range(0, 1)), 4'($urandom_range(1, 3)), 20'h0,
                         8'($urandom_range(0, 63))};
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
